// File: rtl/voq_out_scheduler.sv
// Per-output-port VOQ scheduler: arbitrates whole packets across PORT_NUB VOQs and reframes shared-buffer reads.
// Optional SCHED_STARVE_GUARD_EN: after STARVE_LIMIT strict-priority wins over a waiting queue, force one round-robin pick.
module voq_out_scheduler #(
  parameter int PORT_NUB     = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WIDTH_SEL    = $clog2(PORT_NUB),
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_NUB-1:0]   empty,
  input  logic [PORT_NUB-1:0]   head_eop,
  input  logic                  qos_controll,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rd_en,
  output logic [WIDTH_SEL-1:0]  rd_sel,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  error
);
  localparam int                   TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]        TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH_SEL-1:0] SEL_MAX = WIDTH_SEL'(PORT_NUB - 1);
  localparam logic [WIDTH_SEL:0]   NUB_W   = (WIDTH_SEL + 1)'(PORT_NUB);

  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;

  logic [PORT_NUB-1:0]  req;
  logic [WIDTH_SEL-1:0] grant, rr_ptr, rr_pick, sp_pick, pick, grant_inc;
  logic [WIDTH_SEL:0]   rr_idx;
  logic                 rr_hit, use_rr, arb, fin, abort, first;
  logic [TW-1:0]        to_cnt;

  assign req       = ~empty;
  assign grant_inc = (grant == SEL_MAX) ? '0 : grant + WIDTH_SEL'(1);

  // round-robin: first requester at or after rr_ptr, wrapping
  always_comb begin
    rr_pick = rr_ptr;
    rr_hit  = 1'b0;
    rr_idx  = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      rr_idx = {1'b0, rr_ptr} + (WIDTH_SEL + 1)'(i);
      if (rr_idx >= NUB_W) rr_idx = rr_idx - NUB_W;
      if (!rr_hit && req[rr_idx[WIDTH_SEL-1:0]]) begin
        rr_pick = rr_idx[WIDTH_SEL-1:0];
        rr_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    sp_pick = '0;
    for (int i = PORT_NUB - 1; i >= 0; i--)
      if (req[i]) sp_pick = WIDTH_SEL'(i);
  end

`ifdef SCHED_STARVE_GUARD_EN
  localparam int            SCW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
  logic [SCW-1:0]      starve_cnt;
  logic [PORT_NUB-1:0] lower_req;

  assign use_rr    = ~qos_controll | (starve_cnt == STARVE_MAX);
  // requesters with a higher index than the winner are the ones being starved
  assign lower_req = req & ~((PORT_NUB'(2) << pick) - PORT_NUB'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 starve_cnt <= '0;
    else if (arb) begin
      if (use_rr || (lower_req == '0))          starve_cnt <= '0;
      else                                      starve_cnt <= starve_cnt + SCW'(1);
    end
  end
`else
  assign use_rr = ~qos_controll;
`endif

  assign pick = use_rr ? rr_pick : sp_pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    arb     = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        arb     = 1'b1;
        state_d = XFER;
      end
      XFER: begin
        rd_en = ready & ~empty[grant];
        if (rd_en && head_eop[grant]) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (ready && empty[grant] && (to_cnt == TO_LAST)) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant  <= '0;
      rr_ptr <= '0;
      to_cnt <= '0;
      first  <= 1'b0;
      rd_vld <= 1'b0;
      rd_sop <= 1'b0;
      rd_eop <= 1'b0;
      error  <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      rd_sop <= rd_en & first;
      rd_eop <= fin;
      error  <= abort;
      if (arb) begin
        grant  <= pick;
        first  <= 1'b1;
        to_cnt <= '0;
      end
      // stall cycles (ready=0) freeze the timeout; only starved cycles count
      if (rd_en) begin
        first  <= 1'b0;
        to_cnt <= '0;
      end else if (state_q == XFER && ready && empty[grant]) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (fin || abort) begin
        rr_ptr <= grant_inc;
        to_cnt <= '0;
      end
    end
  end

  assign rd_sel  = (state_q == XFER) ? grant : '0;
  // shared buffer already registers its read port, so data_in lines up with rd_vld
  assign rd_data = rd_vld ? data_in : '0;

endmodule

// File: tb/tb_voq_out_scheduler.sv
// Directed bench for voq_out_scheduler: behavioural VOQ/shared-buffer model plus negedge output monitor.
module tb_voq_out_scheduler;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  empty, head_eop;
  logic          qos_controll = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en, rd_sop, rd_eop, rd_vld, error;
  logic [SW-1:0] rd_sel;
  logic [DW-1:0] rd_data;

  voq_out_scheduler #(.PORT_NUB(N), .DATA_WIDTH(DW), .WIDTH_SEL(SW), .TIMEOUT(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .head_eop(head_eop), .qos_controll(qos_controll),
    .ready(ready), .data_in(data_in), .rd_en(rd_en), .rd_sel(rd_sel), .rd_sop(rd_sop),
    .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data), .error(error)
  );

  always #5 clk = ~clk;

  // VOQ model: {eop, data} words; tasks advance tail, the read port advances head
  logic [16:0] mem [N][32];
  int head [N] = '{default: 0};
  int tail [N] = '{default: 0};
  int cyc = 0;
  int errs = 0;
  int checks = 0;

  always_comb begin
    empty    = '0;
    head_eop = '0;
    for (int k = 0; k < N; k++) begin
      empty[k]    = (head[k] == tail[k]);
      head_eop[k] = mem[k][head[k] % 32][16];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      data_in      <= mem[rd_sel][head[rd_sel] % 32][15:0];
      head[rd_sel] <= head[rd_sel] + 1;
    end
  end

  logic [15:0] log_d [256];
  logic        log_s [256];
  logic        log_e [256];
  int          log_c [256];
  int          log_n = 0;
  int          en_c [256];
  int          en_n = 0;
  int          en_bad = 0;
  int          err_n = 0;
  int          err_c = 0;

  always @(negedge clk) begin
    if (rd_vld) begin
      log_d[log_n % 256] <= rd_data;
      log_s[log_n % 256] <= rd_sop;
      log_e[log_n % 256] <= rd_eop;
      log_c[log_n % 256] <= cyc;
      log_n <= log_n + 1;
    end
    if (rd_en) begin
      en_c[en_n % 256] <= cyc;
      en_n <= en_n + 1;
      if (!ready) en_bad <= en_bad + 1;
    end
    if (error) begin
      err_n <= err_n + 1;
      err_c <= cyc;
    end
  end

  task automatic push(input int q, input logic [15:0] d, input logic eop);
    mem[q][tail[q] % 32] = {eop, d};
    tail[q] = tail[q] + 1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    for (int k = 0; k < N; k++) tail[k] = head[k];
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wait_cyc(2);
    checks += 7;
    if (rd_en   !== 1'b0) begin errs++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    if (rd_vld  !== 1'b0) begin errs++; $display("FAIL reset_rd_vld got=%b exp=0", rd_vld); end
    if (rd_sop  !== 1'b0) begin errs++; $display("FAIL reset_rd_sop got=%b exp=0", rd_sop); end
    if (rd_eop  !== 1'b0) begin errs++; $display("FAIL reset_rd_eop got=%b exp=0", rd_eop); end
    if (error   !== 1'b0) begin errs++; $display("FAIL reset_error got=%b exp=0", error); end
    if (rd_sel  !== 2'd0) begin errs++; $display("FAIL reset_rd_sel got=%0d exp=0", rd_sel); end
    if (rd_data !== 16'h0) begin errs++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
    do_reset();
  endtask

  task automatic test_rr();
    logic [15:0] exp_d [12];
    int m;
    exp_d = '{16'h0001, 16'h0002, 16'h0003, 16'h2001, 16'h2002, 16'h2003,
              16'h0004, 16'h0005, 16'h0006, 16'h2004, 16'h2005, 16'h2006};
    do_reset();
    qos_controll = 1'b0;
    ready = 1'b1;
    m = log_n;
    for (int i = 0; i < 6; i++) begin
      push(0, 16'h0000 + 16'(i + 1), (i % 3) == 2);
      push(2, 16'h2000 + 16'(i + 1), (i % 3) == 2);
    end
    wait_cyc(30);
    checks++;
    if (log_n - m !== 12) begin errs++; $display("FAIL rr_count got=%0d exp=12", log_n - m); end
    for (int i = 0; i < 12; i++) begin
      checks += 3;
      if (log_d[m + i] !== exp_d[i]) begin errs++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, log_d[m + i], exp_d[i]); end
      if (log_s[m + i] !== ((i % 3) == 0)) begin errs++; $display("FAIL rr_sop[%0d] got=%b", i, log_s[m + i]); end
      if (log_e[m + i] !== ((i % 3) == 2)) begin errs++; $display("FAIL rr_eop[%0d] got=%b", i, log_e[m + i]); end
      if (i > 0) begin
        checks++;
        if (log_c[m + i] - log_c[m + i - 1] !== (((i % 3) == 0) ? 2 : 1)) begin
          errs++;
          $display("FAIL rr_gap[%0d] got=%0d exp=%0d", i, log_c[m + i] - log_c[m + i - 1], ((i % 3) == 0) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_strict();
    logic [15:0] exp_d [9];
    int m;
`ifdef SCHED_STARVE_GUARD_EN
    exp_d = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h3001, 16'h1005, 16'h1006, 16'h1007, 16'h1008};
`else
    exp_d = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'h1008, 16'h3001};
`endif
    do_reset();
    qos_controll = 1'b1;
    ready = 1'b1;
    m = log_n;
    for (int i = 0; i < 8; i++) push(1, 16'h1001 + 16'(i), 1'b1);
    push(3, 16'h3001, 1'b1);
    wait_cyc(30);
    checks++;
    if (log_n - m !== 9) begin errs++; $display("FAIL sp_count got=%0d exp=9", log_n - m); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (log_d[m + i] !== exp_d[i]) begin errs++; $display("FAIL sp_data[%0d] got=%h exp=%h", i, log_d[m + i], exp_d[i]); end
    end
    qos_controll = 1'b0;
  endtask

  task automatic test_backpressure();
    int m, me, mb;
    do_reset();
    qos_controll = 1'b0;
    ready = 1'b1;
    m = log_n; me = en_n; mb = en_bad;
    for (int i = 0; i < 4; i++) push(0, 16'h0A01 + 16'(i), i == 3);
    wait_cyc(1);           // transfer cycle 1: first word read
    wait_cyc(1);
    ready = 1'b0;          // transfer cycles 2..4 stalled
    wait_cyc(3);
    ready = 1'b1;
    wait_cyc(8);
    checks += 3;
    if (en_n - me !== 4) begin errs++; $display("FAIL bp_rd_en_count got=%0d exp=4", en_n - me); end
    if (en_bad - mb !== 0) begin errs++; $display("FAIL bp_rd_en_while_stalled got=%0d exp=0", en_bad - mb); end
    if (log_n - m !== 4) begin errs++; $display("FAIL bp_vld_count got=%0d exp=4", log_n - m); end
    for (int i = 0; i < 4; i++) begin
      checks += 4;
      if (log_d[m + i] !== 16'h0A01 + 16'(i)) begin errs++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, log_d[m + i], 16'h0A01 + 16'(i)); end
      if (log_c[m + i] !== en_c[me + i] + 1) begin errs++; $display("FAIL bp_vld_lat[%0d] got=%0d exp=%0d", i, log_c[m + i], en_c[me + i] + 1); end
      if (log_s[m + i] !== (i == 0)) begin errs++; $display("FAIL bp_sop[%0d] got=%b", i, log_s[m + i]); end
      if (log_e[m + i] !== (i == 3)) begin errs++; $display("FAIL bp_eop[%0d] got=%b", i, log_e[m + i]); end
    end
    checks++;
    if (en_c[me + 1] - en_c[me] !== 4) begin errs++; $display("FAIL bp_stall_len got=%0d exp=4", en_c[me + 1] - en_c[me]); end
  endtask

  task automatic test_timeout();
    int m, me, mr;
    do_reset();
    qos_controll = 1'b0;
    ready = 1'b1;
    m = log_n; me = en_n; mr = err_n;
    push(0, 16'h0B01, 1'b0);
    push(0, 16'h0B02, 1'b0);
    push(1, 16'h1C01, 1'b1);   // neighbour waits until the abort returns to IDLE
    for (int i = 0; i < 150 && err_n == mr; i++) wait_cyc(1);
    checks++;
    if (err_n == mr) begin errs++; $display("FAIL to_wait got=no_error exp=error_within_150"); end
    wait_cyc(6);
    checks += 9;
    if (err_n - mr !== 1) begin errs++; $display("FAIL to_err_pulses got=%0d exp=1", err_n - mr); end
    // 64 starved cycles after the last read, error registers on the following edge
    if (err_c !== en_c[me + 1] + 65) begin errs++; $display("FAIL to_err_cycle got=%0d exp=%0d", err_c, en_c[me + 1] + 65); end
    if (en_n - me !== 3) begin errs++; $display("FAIL to_rd_en_count got=%0d exp=3", en_n - me); end
    if (log_n - m !== 3) begin errs++; $display("FAIL to_vld_count got=%0d exp=3", log_n - m); end
    if (log_e[m] !== 1'b0 || log_e[m + 1] !== 1'b0) begin errs++; $display("FAIL to_no_eop got=%b%b exp=00", log_e[m], log_e[m + 1]); end
    if (log_d[m + 1] !== 16'h0B02) begin errs++; $display("FAIL to_word2 got=%h exp=0b02", log_d[m + 1]); end
    if (log_d[m + 2] !== 16'h1C01) begin errs++; $display("FAIL to_next_grant got=%h exp=1c01", log_d[m + 2]); end
    if (log_s[m + 2] !== 1'b1 || log_e[m + 2] !== 1'b1) begin errs++; $display("FAIL to_next_frame got=%b%b exp=11", log_s[m + 2], log_e[m + 2]); end
    if (error !== 1'b0) begin errs++; $display("FAIL to_err_single got=%b exp=0", error); end
  endtask

  task automatic test_async_reset();
    int m, mr;
    do_reset();
    qos_controll = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) push(2, 16'h2D01 + 16'(i), i == 7);
    wait_cyc(2);
    #2;
    checks += 2;
    if (rd_en !== 1'b1)  begin errs++; $display("FAIL ar_pre_rd_en got=%b exp=1", rd_en); end
    if (rd_vld !== 1'b1) begin errs++; $display("FAIL ar_pre_rd_vld got=%b exp=1", rd_vld); end
    mr = err_n;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (rd_en  !== 1'b0) begin errs++; $display("FAIL ar_rd_en got=%b exp=0", rd_en); end
    if (rd_vld !== 1'b0) begin errs++; $display("FAIL ar_rd_vld got=%b exp=0", rd_vld); end
    if (rd_sop !== 1'b0) begin errs++; $display("FAIL ar_rd_sop got=%b exp=0", rd_sop); end
    if (rd_eop !== 1'b0) begin errs++; $display("FAIL ar_rd_eop got=%b exp=0", rd_eop); end
    if (error  !== 1'b0) begin errs++; $display("FAIL ar_error got=%b exp=0", error); end
    for (int k = 0; k < N; k++) tail[k] = head[k];
    wait_cyc(1);
    rst_n = 1'b1;
    m = log_n;
    push(2, 16'h2D11, 1'b1);
    push(0, 16'h0D11, 1'b1);
    wait_cyc(8);
    checks += 4;
    if (log_n - m !== 2) begin errs++; $display("FAIL ar_count got=%0d exp=2", log_n - m); end
    if (log_d[m] !== 16'h0D11) begin errs++; $display("FAIL ar_first_grant got=%h exp=0d11", log_d[m]); end
    if (log_d[m + 1] !== 16'h2D11) begin errs++; $display("FAIL ar_second_grant got=%h exp=2d11", log_d[m + 1]); end
    if (err_n !== mr) begin errs++; $display("FAIL ar_no_error got=%0d exp=%0d", err_n, mr); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [5];
    int m;
    exp_d = '{16'h0E01, 16'h1E01, 16'h2E01, 16'h3E01, 16'h0E02};
    do_reset();
    qos_controll = 1'b0;
    ready = 1'b1;
    m = log_n;
    push(0, 16'h0E01, 1'b1);
    push(0, 16'h0E02, 1'b1);
    push(1, 16'h1E01, 1'b1);
    push(2, 16'h2E01, 1'b1);
    push(3, 16'h3E01, 1'b1);
    wait_cyc(16);
    checks++;
    if (log_n - m !== 5) begin errs++; $display("FAIL b2b_count got=%0d exp=5", log_n - m); end
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (log_d[m + i] !== exp_d[i]) begin errs++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, log_d[m + i], exp_d[i]); end
      if (log_s[m + i] !== 1'b1 || log_e[m + i] !== 1'b1) begin
        errs++;
        $display("FAIL b2b_sop_eop[%0d] got=%b%b exp=11", i, log_s[m + i], log_e[m + i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_strict();
    test_backpressure();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/voq_out_scheduler.md
Name: voq_out_scheduler

Overview:
- Per-output-port scheduler for the shared-cache switch; one instance per output port.
- Chooses which input's virtual output queue (VOQ) feeds this port and issues rd_en/rd_sel to the shared buffer.
- Grants whole packets: a grant is held from the sop word to the eop word.
- Two modes: round-robin, or strict priority (lowest input index wins). Reframes returned data as rd_sop/rd_eop/rd_vld toward the port.

Parameters:
PORT_NUB, 4, number of input ports / VOQs feeding this output
DATA_WIDTH, 16, width of the data word
WIDTH_SEL, $clog2(PORT_NUB), width of the queue select
TIMEOUT, 64, cycles a granted queue may stay empty mid-packet before abort
STARVE_LIMIT, 4, consecutive strict-priority packets before a forced fair pick (optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
empty  in  PORT_NUB  bit k=1: VOQ k (input k to this port) is empty
head_eop  in  PORT_NUB  bit k=1: head word of VOQ k is a packet's last word
qos_controll  in  1  0=round-robin, 1=strict priority
ready  in  1  downstream can accept a word issued this cycle
data_in  in  DATA_WIDTH  shared-buffer read data, valid 1 cycle after rd_en
rd_en  out  1  pop head of VOQ rd_sel
rd_sel  out  WIDTH_SEL  queue being read
rd_sop  out  1  first word of packet on rd_data
rd_eop  out  1  last word of packet on rd_data
rd_vld  out  1  rd_data valid
rd_data  out  DATA_WIDTH  registered data_in
error  out  1  one-cycle pulse on mid-packet timeout abort

Behaviour:
- Clock and reset: one clock clk. Reset is asynchronous, active-low on rst_n.
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; timeout counter=0; starve counter=0.
- State IDLE:
  - Requests are req = ~empty.
  - If req==0, stay in IDLE.
  - Otherwise, select in the same cycle, register grant, go to XFER. rd_en is not asserted in IDLE.
- Arbitration:
  - Round-robin: first k with req[k]=1, searching from rr_ptr upward and wrapping modulo PORT_NUB.
  - Strict priority: lowest k with req[k]=1.
  - qos_controll is sampled only at arbitration; a change mid-packet has no effect until the next packet.
- State XFER:
  - rd_sel=grant for the whole state.
  - rd_en = ready & ~empty[grant] (combinational from registered state).
  - When rd_en & head_eop[grant]: go to IDLE next cycle and set rr_ptr=(grant+1) mod PORT_NUB. Next packet can be granted the cycle after; rd_en gap is 1 cycle minimum between packets.
  - ready=0: hold, no read, timeout counter unchanged.
- Timeout:
  - Counter increments each XFER cycle with empty[grant]=1 and clears on any rd_en.
  - On reaching TIMEOUT: pulse error for 1 cycle, go to IDLE, and advance rr_ptr past grant.
  - No rd_eop is generated for the aborted packet.
- Output pipeline (1-cycle latency):
  - rd_vld(t+1) = rd_en(t); rd_data(t+1) = data_in(t+1) registered.
  - rd_sop(t+1) = first rd_en of the grant; rd_eop(t+1) = rd_en & head_eop[grant] at t.
  - A single-word packet has rd_sop=rd_eop=1 in the same cycle.
- Simultaneous events:
  - The last-word read and TIMEOUT cannot coincide (a read clears the counter).
  - A request arriving on the granted queue's neighbour during XFER is ignored until IDLE.
- Reset mid-packet: outputs clear immediately; any partial packet is dropped; no error pulse.

Optional Feature:
- Macro: SCHED_STARVE_GUARD_EN.
- Defined:
  - In strict-priority mode, count consecutive packets granted while some lower-priority queue (higher index) was requesting.
  - On reaching STARVE_LIMIT, the next arbitration uses the round-robin search from rr_ptr; the counter then clears.
  - The counter also clears on any grant with no other requester, and in round-robin mode.
- Not defined: strict priority is pure; no counter logic is synthesized.

Test Plan:
1. RR fairness: qos=0, ready=1, VOQs 0 and 2 each hold two 3-word packets → grants 0,2,0,2. Each packet shows rd_vld for 3 cycles with sop on word 1 and eop on word 3, and a 1-cycle gap between packets.
2. Strict priority: qos=1, VOQ1 and VOQ3 nonempty with 1-word packets, VOQ1 refilled continuously → only queue 1 served. With SCHED_STARVE_GUARD_EN, queue 3 is served after exactly 4 queue-1 packets.
3. Backpressure: 4-word packet, ready low for cycles 2–4 of transfer → exactly 4 rd_en pulses, none while ready=0. rd_vld follows each rd_en by 1 cycle; data order is preserved.
4. Mid-packet underflow: granted VOQ goes empty after word 2 and stays empty → error pulses once 64 cycles after the last rd_en. Scheduler returns to IDLE, no rd_eop is seen, and the next requester is granted.
5. Async reset mid-packet: rst_n low while in XFER, between clock edges → rd_en/rd_vld/rd_sop/rd_eop/error drop to 0 immediately. After release, the first grant in RR mode goes to queue 0.
6. Single-word packets back-to-back on all 4 queues, qos=0 → rd_sop=rd_eop=1 on each word, service order 0,1,2,3,0.
